// File: rtl/ram_arbiter.sv
// Shares one single-port word RAM between the instruction-fetch and data ports.
// Data has fixed priority, bounded by a starvation guard; sub-word stores are read-modify-write.
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 30,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_re,
  output logic                  ram_we,
  input  logic [31:0]           ram_dout
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD, MERGE, ACK} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // 1 = data port, 0 = instruction port
  logic [SW-1:0]   starve_q, starve_d;
  logic            grant_d;
  logic [31:0]     merged;

  assign grant_d = d_req && (!i_req || (starve_q < LIMIT));
  assign i_rdata = ram_dout;
  assign d_rdata = ram_dout;

  always_comb begin
    merged = ram_dout;
    for (int n = 0; n < 4; n++) begin
      if (d_be[n]) merged[8*n +: 8] = d_wdata[8*n +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    ram_addr = owner_q ? d_addr : i_addr;
    ram_din  = d_wdata;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d  = 1'b1;
          ram_addr = d_addr;
          if (!i_req) starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
          if (!d_we) begin
            ram_re  = 1'b1;
            state_d = RD;
          end else if (d_be == 4'b1111) begin
            ram_we  = 1'b1;
            state_d = ACK;
          end else if (d_be != 4'b0000) begin
            ram_re  = 1'b1;
            state_d = MERGE;
          end else begin
            state_d = ACK;
          end
        end else if (i_req) begin
          owner_d  = 1'b0;
          starve_d = '0;
          ram_addr = i_addr;
          ram_re   = 1'b1;
          state_d  = RD;
        end
      end
      RD: begin
        if (owner_q) d_ack = 1'b1;
        else         i_ack = 1'b1;
        state_d = IDLE;
      end
      MERGE: begin
        ram_we   = 1'b1;
        ram_addr = d_addr;
        ram_din  = merged;
        state_d  = ACK;
      end
      ACK: begin
        d_ack   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must suppress any in-flight write or ack, including a MERGE write.
    if (reset) begin
      ram_re = 1'b0;
      ram_we = 1'b0;
      i_ack  = 1'b0;
      d_ack  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus, queued expected acks, negedge monitor.
module tb_ram_arbiter;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, ram_addr;
  logic [31:0]   d_wdata, i_rdata, d_rdata, ram_din, ram_dout;
  logic [3:0]    d_be;
  logic          i_ack, d_ack, ram_re, ram_we;

  logic [31:0]   mem [0:255];

  typedef struct {
    bit          is_d;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_re(ram_re), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Registered-read single-port RAM model
  always @(posedge clk) begin
    if (ram_re) ram_dout <= mem[ram_addr[7:0]];
    if (ram_we) mem[ram_addr[7:0]] <= ram_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (i_ack || d_ack)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b want none", i_ack, d_ack);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("ack_port", {31'b0, d_ack}, {31'b0, e.is_d});
        if (e.chk) check("ack_data", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic d_issue(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
  endtask

  initial begin
    int acks;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hAABBCCDD;
    mem[8'h50] = 32'h55555555;
    mem[8'h60] = 32'h66666666;
    mem[8'h70] = 32'h77777777;
    ram_dout = 32'h0;
    reset = 1'b1;
    i_req = 1'b1; i_addr = 30'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h20; d_wdata = 32'h0; d_be = 4'h0;

    // Reset: requests present but nothing may happen
    smp();
    check("rst_ram_re", {31'b0, ram_re}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    drv();
    i_req = 1'b0; d_req = 1'b0;
    drv();
    reset = 1'b0;
    drv();

    // Instruction read
    i_req = 1'b1; i_addr = 30'h10;
    sbq.push_back('{is_d: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
    smp();
    check("ird_c0_re", {31'b0, ram_re}, 32'd1);
    check("ird_c0_addr", {2'b0, ram_addr}, 32'h10);
    check("ird_c0_ack", {31'b0, i_ack}, 32'd0);
    drv(); smp();
    check("ird_c1_ack", {31'b0, i_ack}, 32'd1);
    drv(); i_req = 1'b0; smp();
    check("ird_single_ack", {31'b0, i_ack}, 32'd0);

    // Full-word store then load
    drv();
    d_issue(1'b1, 30'h20, 32'h12345678, 4'b1111);
    sbq.push_back('{is_d: 1'b1, chk: 1'b0, data: 32'h0});
    smp();
    check("fst_c0_we", {31'b0, ram_we}, 32'd1);
    check("fst_c0_din", ram_din, 32'h12345678);
    check("fst_c0_addr", {2'b0, ram_addr}, 32'h20);
    check("fst_c0_ack", {31'b0, d_ack}, 32'd0);
    drv(); smp();
    check("fst_c1_ack", {31'b0, d_ack}, 32'd1);
    check("fst_c1_we", {31'b0, ram_we}, 32'd0);
    drv(); d_req = 1'b0;
    drv();
    d_issue(1'b0, 30'h20, 32'h0, 4'b0000);
    sbq.push_back('{is_d: 1'b1, chk: 1'b1, data: 32'h12345678});
    smp();
    check("ld20_c0_re", {31'b0, ram_re}, 32'd1);
    drv(); smp();
    check("ld20_c1_ack", {31'b0, d_ack}, 32'd1);
    drv(); d_req = 1'b0;

    // Partial store read-modify-write
    drv();
    d_issue(1'b1, 30'h30, 32'h11223344, 4'b0101);
    sbq.push_back('{is_d: 1'b1, chk: 1'b0, data: 32'h0});
    smp();
    check("pst_c0_re", {31'b0, ram_re}, 32'd1);
    check("pst_c0_we", {31'b0, ram_we}, 32'd0);
    drv(); smp();
    check("pst_c1_we", {31'b0, ram_we}, 32'd1);
    check("pst_c1_din", ram_din, 32'hAA22CC44);
    check("pst_c1_addr", {2'b0, ram_addr}, 32'h30);
    check("pst_c1_ack", {31'b0, d_ack}, 32'd0);
    drv(); smp();
    check("pst_c2_ack", {31'b0, d_ack}, 32'd1);
    drv(); d_req = 1'b0;
    drv();
    d_issue(1'b0, 30'h30, 32'h0, 4'b0000);
    sbq.push_back('{is_d: 1'b1, chk: 1'b1, data: 32'hAA22CC44});
    drv(); smp();
    check("ld30_ack", {31'b0, d_ack}, 32'd1);
    drv(); d_req = 1'b0;

    // Arbitration with both ports held: D, D, I, D, D, I
    drv();
    i_req = 1'b1; i_addr = 30'h50;
    d_issue(1'b0, 30'h60, 32'h0, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      if (k == 2 || k == 5) sbq.push_back('{is_d: 1'b0, chk: 1'b1, data: 32'h55555555});
      else                  sbq.push_back('{is_d: 1'b1, chk: 1'b1, data: 32'h66666666});
    end
    acks = 0;
    for (int c = 0; c < 40 && acks < 6; c++) begin
      smp();
      if (i_ack || d_ack) acks++;
    end
    check("arb_ack_count", acks, 32'd6);
    drv(); i_req = 1'b0; d_req = 1'b0;

    // Zero byte-enable store: no RAM access at all
    drv();
    d_issue(1'b1, 30'h70, 32'hFFFFFFFF, 4'b0000);
    sbq.push_back('{is_d: 1'b1, chk: 1'b0, data: 32'h0});
    smp();
    check("zbe_c0_access", {30'b0, ram_re, ram_we}, 32'd0);
    check("zbe_c0_ack", {31'b0, d_ack}, 32'd0);
    drv(); smp();
    check("zbe_c1_ack", {31'b0, d_ack}, 32'd1);
    check("zbe_c1_access", {30'b0, ram_re, ram_we}, 32'd0);
    drv(); d_req = 1'b0; smp();
    check("zbe_mem", mem[8'h70], 32'h77777777);

    // Reset asserted in MERGE aborts the store
    drv();
    d_issue(1'b1, 30'h40, 32'hFFFFFFFF, 4'b0011);
    smp();
    check("rmg_c0_re", {31'b0, ram_re}, 32'd1);
    drv();
    reset = 1'b1; d_req = 1'b0;
    smp();
    check("rmg_merge_we", {31'b0, ram_we}, 32'd0);
    check("rmg_merge_ack", {31'b0, d_ack}, 32'd0);
    drv();
    reset = 1'b0;
    smp();
    check("rmg_post_ack", {31'b0, d_ack}, 32'd0);
    drv(); smp();
    check("rmg_mem", mem[8'h40], 32'h00000000);
    drv();
    i_req = 1'b1; i_addr = 30'h10;
    sbq.push_back('{is_d: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
    smp();
    check("rmg_i_re", {31'b0, ram_re}, 32'd1);
    drv(); smp();
    check("rmg_i_ack", {31'b0, i_ack}, 32'd1);
    drv(); i_req = 1'b0;
    drv(); drv(); smp();

    check("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port word RAM between the CPU instruction-fetch port and data load/store port.
- Sequences every RAM access: fixed data priority with an instruction-starvation guard.
- Sub-word stores are done as read-modify-write using byte enables, because the RAM has only a whole-word write.
- Sits between the core's two memory ports and the RAM instance.

Parameters:
ADDR_WIDTH, 30, word address width on all ports
STARVE_LIMIT, 2, consecutive data grants allowed while i_req waits before the instruction port is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  instruction read request; held with i_addr until i_ack
i_addr  in  ADDR_WIDTH  instruction word address
i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
i_rdata  out  32  instruction word
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_WIDTH  data word address
d_wdata  in  32  store data, byte lanes aligned
d_be  in  4  store byte enables; bit n covers bits 8n+7:8n
d_ack  out  1  one-cycle completion pulse
d_rdata  out  32  load word, valid while d_ack
ram_addr  out  ADDR_WIDTH  RAM word address
ram_din  out  32  RAM write data
ram_re  out  1  RAM read enable
ram_we  out  1  RAM write enable
ram_dout  in  32  RAM registered read data, valid the cycle after ram_re

Behaviour:
- States:
  - IDLE: arbitrate.
  - RD: read data returning.
  - MERGE: write merged word.
  - ACK: complete the write.
- Register owner (I or D) at grant.
- Arbitration in IDLE, evaluated combinationally in that cycle:
  - Grant D if d_req and (not i_req, or starve_cnt < STARVE_LIMIT).
  - Otherwise grant I if i_req.
- starve_cnt:
  - Increments on each D grant made while i_req=1.
  - Clears on any I grant, or on a D grant with i_req=0.
  - Saturates at STARVE_LIMIT.
- IDLE grant actions (ram_addr driven from the granted port in the grant cycle):
  - I read, or D load: ram_re=1 -> RD.
  - D store, d_be=4'b1111: ram_we=1, ram_din=d_wdata -> ACK.
  - D store, d_be partial, nonzero: ram_re=1 -> MERGE.
  - D store, d_be=0: no RAM access -> ACK.
- RD:
  - Owner's ack=1; owner's rdata = ram_dout.
  - ram_re=0, ram_we=0 -> IDLE.
- MERGE:
  - ram_we=1; ram_addr=d_addr.
  - ram_din byte n = d_be[n] ? d_wdata byte n : ram_dout byte n.
  - -> ACK.
- ACK: d_ack=1, no RAM access -> IDLE.
- Latency (request seen in IDLE with no contention to ack):
  - Read: 1 cycle.
  - Full store: 1 cycle.
  - Partial store: 2 cycles.
- No grant is made in RD/MERGE/ACK, so back-to-back transactions are separated by at least one IDLE cycle.
- Outputs are combinational from state/owner/inputs:
  - Outside their defined cycles, ram_re, ram_we, i_ack and d_ack are 0.
  - i_rdata/d_rdata are don't-care when their ack is 0; implementation drives ram_dout.
  - ram_addr/ram_din are don't-care when both enables are 0.
- Reset:
  - While reset=1: ram_re=ram_we=i_ack=d_ack=0.
  - Next state IDLE; starve_cnt=0; owner=I.
  - Reset asserted mid-transaction, including in MERGE, aborts it: no write occurs and no ack is issued. Requesters reissue.
- A request dropped before its ack is a protocol violation; behaviour is undefined and not checked.
- Addresses pass through unmodified; no alignment or range checks.

Test Plan:
- Instruction read: RAM[0x10]=0xDEADBEEF, i_req with i_addr=0x10 -> ram_re in cycle 0; i_ack with i_rdata=0xDEADBEEF in cycle 1; only one ack.
- Full store then load:
  - Store: d_we=1, d_addr=0x20, d_wdata=0x12345678, be=1111 -> ram_we cycle 0, d_ack cycle 1.
  - Load 0x20 -> d_rdata=0x12345678.
- Partial store RMW: RAM[0x30]=0xAABBCCDD; store be=0101, wdata=0x11223344 -> ram_re cycle 0, ram_we cycle 1 with ram_din=0xAA22CC44, d_ack cycle 2; subsequent load returns 0xAA22CC44.
- Arbitration and starvation guard (STARVE_LIMIT=2): i_req and d_req held continuously, d loads back to back -> grant order D, D, I, D, D, I; i_ack within 3 transactions of raising i_req.
- Zero byte-enable store: be=0000 -> no ram_re/ram_we ever; d_ack one cycle after grant; RAM unchanged.
- Reset in MERGE: partial store to 0x40 (RAM=0x00000000), reset asserted in MERGE cycle -> ram_we=0 that cycle, no d_ack; RAM[0x40] still 0; after release, a new i_req is served normally.
